// File: rtl/id_ex_pipe_stage.sv
// rtl/id_ex_pipe_stage.sv - ID->EX pipeline stage with valid/ready, flush and stall counter
// Define ID_EX_SKID_EN to add a one-entry skid buffer that registers id_ready_o.
module id_ex_pipe_stage #(
  parameter int unsigned          PAYLOAD_W = 80,
  parameter logic [PAYLOAD_W-1:0] RESET_VAL = '0,
  parameter int unsigned          CNT_W     = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 flush_i,
  input  logic                 id_valid_i,
  output logic                 id_ready_o,
  input  logic [PAYLOAD_W-1:0] id_payload_i,
  output logic                 ex_valid_o,
  input  logic                 ex_ready_i,
  output logic [PAYLOAD_W-1:0] ex_payload_o,
  input  logic                 stall_cnt_clr_i,
  output logic [CNT_W-1:0]     stall_cnt_o
);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_HALF  = 2'd1,
    S_FULL  = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t                 state_q;
  logic [PAYLOAD_W-1:0]   out_payload_q;
  logic [PAYLOAD_W-1:0]   skid_data;
  logic [CNT_W-1:0]       stall_cnt_q;
  logic                   accept;
  logic                   consume;
  logic                   stalled;
  logic                   skid_load;

  assign ex_valid_o   = (state_q != S_EMPTY);
  assign ex_payload_o = out_payload_q;
  assign stall_cnt_o  = stall_cnt_q;
  assign accept       = id_valid_i & id_ready_o;
  assign consume      = ex_valid_o & ex_ready_i;
  assign stalled      = ex_valid_o & ~ex_ready_i;
  // Only reachable with the skid buffer: the single-register build refuses input while stalled.
  assign skid_load    = (state_q == S_HALF) & accept & ~consume;

`ifdef ID_EX_SKID_EN
  logic [PAYLOAD_W-1:0] skid_payload_q;

  // Ready depends only on state, breaking the combinational path from ex_ready_i.
  assign id_ready_o = (state_q != S_FULL);
  assign skid_data  = skid_payload_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      skid_payload_q <= RESET_VAL;
    end else if (!flush_i && skid_load) begin
      skid_payload_q <= id_payload_i;
    end
  end
`else
  assign id_ready_o = ~ex_valid_o | ex_ready_i;
  assign skid_data  = out_payload_q;
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q       <= S_EMPTY;
      out_payload_q <= RESET_VAL;
    end else if (flush_i) begin
      state_q <= S_EMPTY;
    end else begin
      case (state_q)
        S_EMPTY: begin
          if (accept) begin
            out_payload_q <= id_payload_i;
            state_q       <= S_HALF;
          end
        end
        S_HALF: begin
          if (accept && consume) begin
            out_payload_q <= id_payload_i;
          end else if (skid_load) begin
            state_q <= S_FULL;
          end else if (consume) begin
            state_q <= S_EMPTY;
          end
        end
        S_FULL: begin
          if (consume) begin
            out_payload_q <= skid_data;
            state_q       <= S_HALF;
          end
        end
        default: state_q <= S_EMPTY;
      endcase
    end
  end

  // Flush cycles do not count as stalls; clear wins over increment.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_cnt_q <= '0;
    end else if (stall_cnt_clr_i) begin
      stall_cnt_q <= '0;
    end else if (stalled && !flush_i && (stall_cnt_q != CNT_MAX)) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_pipe_stage.sv
// tb/tb_id_ex_pipe_stage.sv - self-checking bench for id_ex_pipe_stage
// Works for both builds; ID_EX_SKID_EN selects the model queue depth and ready rule.
module tb_id_ex_pipe_stage;
  localparam int PW = 16;
  localparam int CW = 3;
  localparam logic [PW-1:0] RV = 16'hBEEF;
  localparam int CMAX = (1 << CW) - 1;
`ifdef ID_EX_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic id_valid = 1'b0;
  logic id_ready;
  logic [PW-1:0] id_payload = '0;
  logic ex_valid;
  logic ex_ready = 1'b0;
  logic [PW-1:0] ex_payload;
  logic clr = 1'b0;
  logic [CW-1:0] stall_cnt;

  int n_checks = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;
  logic [PW-1:0] q[$];
  int m_cnt = 0;

  id_ex_pipe_stage #(.PAYLOAD_W(PW), .RESET_VAL(RV), .CNT_W(CW)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush),
    .id_valid_i(id_valid), .id_ready_o(id_ready), .id_payload_i(id_payload),
    .ex_valid_o(ex_valid), .ex_ready_i(ex_ready), .ex_payload_o(ex_payload),
    .stall_cnt_clr_i(clr), .stall_cnt_o(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  function automatic bit m_ready();
    return SKID ? (q.size() < 2) : (q.size() == 0 || ex_ready);
  endfunction

  // Model: FIFO of held payloads (capacity 1 or 2) plus a saturating stall count.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      q.delete();
      m_cnt = 0;
    end else begin
      bit acc;
      bit con;
      acc = id_valid && m_ready();
      con = (q.size() != 0) && ex_ready;
      if (clr) m_cnt = 0;
      else if (!flush && q.size() != 0 && !ex_ready && m_cnt < CMAX) m_cnt++;
      if (flush) q.delete();
      else begin
        if (con) void'(q.pop_front());
        if (acc) q.push_back(id_payload);
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en && !rst) begin
      check("ex_valid", ex_valid, q.size() != 0);
      if (q.size() != 0) check("ex_payload", ex_payload, q[0]);
      check("id_ready", id_ready, m_ready());
      check("stall_cnt", stall_cnt, m_cnt);
`ifdef ID_EX_SKID_EN
      if (q.size() == 2) check("no_accept_full", id_valid & id_ready, 0);
`endif
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    repeat (2) step();
    check("rst_valid", ex_valid, 0);
    check("rst_payload", ex_payload, RV);
    check("rst_cnt", stall_cnt, 0);
    rst = 1'b0;
    #1;
    check("rst_ready", id_ready, 1);
    chk_en = 1'b1;

    // streaming, no bubbles
    id_valid = 1'b1;
    ex_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      id_payload = PW'(i);
      step();
      check("stream_valid", ex_valid, 1);
      check("stream_payload", ex_payload, i);
    end
    check("stream_cnt", stall_cnt, 0);

    // stall for 5 cycles
    id_valid = 1'b0; clr = 1'b1;
    step();
    clr = 1'b0; id_valid = 1'b1; id_payload = 16'h00A5; ex_ready = 1'b0;
    step();
`ifdef ID_EX_SKID_EN
    check("stall_ready_half", id_ready, 1);
`else
    check("stall_ready_half", id_ready, 0);
`endif
    id_payload = 16'h005A;
    repeat (5) step();
    check("stall_payload", ex_payload, 16'h00A5);
    check("stall_cnt5", stall_cnt, 5);
    check("stall_ready", id_ready, 0);
    ex_ready = 1'b1;
    step();
    check("release_1", ex_payload, 16'h005A);
    check("release_1v", ex_valid, 1);
    id_valid = 1'b0;
    step();
    check("release_empty", ex_valid, 0);
    check("release_cnt", stall_cnt, 5);

    // saturation and clear
    clr = 1'b1;
    step();
    clr = 1'b0; id_valid = 1'b1; id_payload = 16'h0033; ex_ready = 1'b0;
    step();
    id_valid = 1'b0;
    repeat (10) step();
    check("sat_cnt", stall_cnt, 7);
    clr = 1'b1;
    step();
    check("clr_cnt", stall_cnt, 0);
    clr = 1'b0;
    step();
    check("clr_then_inc", stall_cnt, 1);

    // flush with output held (FULL in skid build)
    id_valid = 1'b1; id_payload = 16'h0044;
    step();
    check("pre_flush_cnt", stall_cnt, 2);
    flush = 1'b1; id_payload = 16'h0077;
    step();
    check("flush_valid", ex_valid, 0);
    check("flush_cnt", stall_cnt, 2);
    // flush dominating an accept from EMPTY
    ex_ready = 1'b1;
    step();
    check("flush_drop_valid", ex_valid, 0);
    flush = 1'b0; id_valid = 1'b0;
    step();
    check("flush_no_leak", ex_valid, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      id_valid   = ($urandom_range(0, 3) != 0);
      ex_ready   = ($urandom_range(0, 2) != 0);
      flush      = ($urandom_range(0, 19) == 0);
      clr        = ($urandom_range(0, 15) == 0);
      id_payload = PW'($urandom);
      step();
    end

    // asynchronous reset mid-stream
    flush = 1'b0; clr = 1'b0; id_valid = 1'b1; ex_ready = 1'b0; id_payload = 16'h1234;
    repeat (2) step();
    check("pre_rst_valid", ex_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_valid", ex_valid, 0);
    check("async_rst_payload", ex_payload, RV);
    check("async_rst_cnt", stall_cnt, 0);
    id_valid = 1'b0;
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("post_rst_valid", ex_valid, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
